// File: rtl/intbus_interf.sv
// rtl/intbus_interf.sv - word-addressed internal bus between the AXI3 bridge and its slaves
//
// Signals:
//   clk            sole clock, driven by the bus master
//   addr   [AW]    word address
//   wdata  [DW]    write data
//   wr / rd        one-cycle write / read strobes
//   rdata  [DW]    registered read data from the slave
//   rvalid         read response, one cycle after an accepted rd
interface intbus_interf #(
    parameter int D_WIDTH    = 32,
    parameter int ADDR_WIDTH = 28
) (
    input logic clk
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [D_WIDTH-1:0]    wdata;
    logic                  wr;
    logic                  rd;
    logic [D_WIDTH-1:0]    rdata;
    logic                  rvalid;

    modport slave  (input clk, addr, wdata, wr, rd, output rdata, rvalid);
    modport master (input clk, rdata, rvalid, output addr, wdata, wr, rd);
endinterface

// File: rtl/intbus_stream_fifo.sv
// rtl/intbus_stream_fifo.sv - register-mapped TX/RX FIFO pair bridging intbus and valid/ready streams
//
// Registers (word offset from BASE_ADDR):
//   0 TX_DATA  write pushes TX FIFO, read returns 0
//   1 RX_DATA  read pops RX FIFO (0 and sticky rx_unf when empty)
//   2 STATUS   counts, full/empty, sticky tx_ovf / rx_unf
//   3 CTRL     write-only actions: bit0 flush TX, bit1 flush RX, bit2 clear sticky flags
// Ports:
//   int_bus    intbus slave (clk, addr, wdata, wr, rd, rdata, rvalid)
//   rst        synchronous active-high reset
//   tx_data / tx_valid / tx_ready   TX stream out, first-word fall-through
//   rx_data / rx_valid / rx_ready   RX stream in
module intbus_stream_fifo #(
    parameter int                    D_WIDTH    = 32,
    parameter int                    ADDR_WIDTH = 28,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    DEPTH      = 16
) (
    intbus_interf.slave          int_bus,
    input  logic                 rst,
    output logic [D_WIDTH-1:0]   tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [D_WIDTH-1:0]   rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [D_WIDTH-1:0] tx_mem [DEPTH];
    logic [D_WIDTH-1:0] rx_mem [DEPTH];
    logic [AW-1:0]      tx_wp, tx_rp, rx_wp, rx_rp;
    logic [CW-1:0]      tx_cnt, rx_cnt;
    logic               tx_ovf, rx_unf;

    logic [ADDR_WIDTH-1:0] off;
    logic                  hit;
    logic                  wr_act, rd_act;
    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic                  tx_push, tx_pop, tx_ovf_evt, tx_flush;
    logic                  rx_push, rx_pop, rx_unf_evt, rx_flush;
    logic                  flag_clr;
    logic [D_WIDTH-1:0]    rd_mux;
    logic [31:0]           status;

    // Addresses below BASE_ADDR wrap to large offsets and fall out of range.
    assign off    = int_bus.addr - BASE_ADDR;
    assign hit    = (off < ADDR_WIDTH'(4));
    // A simultaneous wr and rd is treated as a write only.
    assign wr_act = int_bus.wr & hit;
    assign rd_act = int_bus.rd & ~int_bus.wr & hit;

    // Full/empty come from the registered counts, i.e. the pre-cycle state.
    assign tx_full  = (tx_cnt == CW'(DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == CW'(DEPTH));
    assign rx_empty = (rx_cnt == '0);

    assign tx_valid = ~tx_empty & ~rst;
    assign rx_ready = ~rx_full & ~rst;
    assign tx_data  = tx_mem[tx_rp];

    assign tx_push    = wr_act & (off[1:0] == 2'd0) & ~tx_full;
    assign tx_ovf_evt = wr_act & (off[1:0] == 2'd0) & tx_full;
    assign tx_pop     = tx_valid & tx_ready;
    assign tx_flush   = wr_act & (off[1:0] == 2'd3) & int_bus.wdata[0];

    assign rx_push    = rx_valid & rx_ready;
    assign rx_pop     = rd_act & (off[1:0] == 2'd1) & ~rx_empty;
    assign rx_unf_evt = rd_act & (off[1:0] == 2'd1) & rx_empty;
    assign rx_flush   = wr_act & (off[1:0] == 2'd3) & int_bus.wdata[1];

    assign flag_clr   = wr_act & (off[1:0] == 2'd3) & int_bus.wdata[2];

    assign status = {10'd0, rx_unf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full,
                     8'(rx_cnt), 8'(tx_cnt)};

    always_comb begin
        rd_mux = '0;
        case (off[1:0])
            2'd1:    rd_mux = rx_empty ? '0 : rx_mem[rx_rp];
            2'd2:    rd_mux = D_WIDTH'(status);
            default: rd_mux = '0;
        endcase
    end

    // Storage arrays carry no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge int_bus.clk) begin
        if (tx_push) tx_mem[tx_wp] <= int_bus.wdata;
        if (rx_push) rx_mem[rx_wp] <= rx_data;
    end

    always_ff @(posedge int_bus.clk) begin
        if (rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else if (tx_flush) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + AW'(1);
            if (tx_pop)  tx_rp <= tx_rp + AW'(1);
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
        end
    end

    always_ff @(posedge int_bus.clk) begin
        if (rst) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else if (rx_flush) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + AW'(1);
            if (rx_pop)  rx_rp <= rx_rp + AW'(1);
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
        end
    end

    // A new event in the same cycle as a clear leaves the flag set.
    always_ff @(posedge int_bus.clk) begin
        if (rst) begin
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
        end else begin
            tx_ovf <= tx_ovf_evt | (tx_ovf & ~flag_clr);
            rx_unf <= rx_unf_evt | (rx_unf & ~flag_clr);
        end
    end

    always_ff @(posedge int_bus.clk) begin
        if (rst) begin
            int_bus.rvalid <= 1'b0;
            int_bus.rdata  <= '0;
        end else begin
            int_bus.rvalid <= rd_act;
            if (rd_act) int_bus.rdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_intbus_stream_fifo.sv
// tb/tb_intbus_stream_fifo.sv - scoreboard bench for intbus_stream_fifo
module tb_intbus_stream_fifo;
    localparam logic [27:0] BASE = 28'h0000100;
    localparam logic [31:0] ST_IDLE = 32'h000A0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    bit drv_rd_mapped = 1'b0;
    bit exp_rv = 1'b0;

    logic [31:0] rd_q[$];
    logic [31:0] tx_q[$];

    always #5 clk = ~clk;

    intbus_interf #(.D_WIDTH(32), .ADDR_WIDTH(28)) bus (.clk(clk));

    intbus_stream_fifo #(
        .D_WIDTH(32), .ADDR_WIDTH(28), .BASE_ADDR(BASE), .DEPTH(16)
    ) dut (
        .int_bus (bus),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready)
    );

    // Expected rvalid: a mapped read seen at an edge answers one cycle later unless reset.
    always @(posedge clk) exp_rv <= rst ? 1'b0 : drv_rd_mapped;

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (bus.rvalid !== exp_rv) begin
                errors++;
                $display("FAIL rvalid_timing: got %b want %b at %0t", bus.rvalid, exp_rv, $time);
            end
            if (bus.rvalid === 1'b1) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rdata_unexpected: got %h want no response", bus.rdata);
                end else begin
                    logic [31:0] e;
                    e = rd_q.pop_front();
                    if (bus.rdata !== e) begin
                        errors++;
                        $display("FAIL rdata: got %h want %h at %0t", bus.rdata, e, $time);
                    end
                end
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                checks++;
                if (tx_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: got %h want no beat", tx_data);
                end else begin
                    logic [31:0] e;
                    e = tx_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL tx_data: got %h want %h at %0t", tx_data, e, $time);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] offs, input logic [31:0] d);
        bus.addr  = BASE + 28'(offs);
        bus.wdata = d;
        bus.wr    = 1'b1;
        step();
        bus.wr    = 1'b0;
    endtask

    task automatic tx_write(input logic [31:0] d, input bit accepted);
        if (accepted) tx_q.push_back(d);
        bus_write(2'd0, d);
    endtask

    task automatic bus_read(input logic [27:0] offs, input logic [31:0] e);
        bus.addr      = BASE + offs;
        bus.rd        = 1'b1;
        drv_rd_mapped = (offs < 28'd4);
        if (offs < 28'd4) rd_q.push_back(e);
        step();
        bus.rd        = 1'b0;
        drv_rd_mapped = 1'b0;
    endtask

    task automatic stream_rx(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data  = base + 32'(i);
            step();
        end
        rx_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (2) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        mon_en = 1'b1;
        checks++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got tx_valid=%b rx_ready=%b want 0 0", tx_valid, rx_ready);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || bus.rvalid !== 1'b0 || bus.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got tx_valid=%b rx_ready=%b rvalid=%b rdata=%h want 0 1 0 0",
                     tx_valid, rx_ready, bus.rvalid, bus.rdata);
        end
        bus_read(28'd2, ST_IDLE);
        settle();
    endtask

    task automatic test_tx_basic();
        tx_ready = 1'b1;
        tx_write(32'h11, 1'b1);
        tx_write(32'h22, 1'b1);
        tx_write(32'h33, 1'b1);
        repeat (3) step();
        tx_ready = 1'b0;
        checks++;
        if (tx_q.size() != 0) begin
            errors++;
            $display("FAIL tx_basic_drain: got %0d left want 0", tx_q.size());
        end
        bus_read(28'd2, ST_IDLE);
        settle();
    endtask

    task automatic test_tx_overflow();
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) tx_write(32'h100 + 32'(i), i < 16);
        bus_read(28'd2, 32'h00190010);
        tx_ready = 1'b1;
        for (int k = 0; k < 40 && tx_q.size() != 0; k++) step();
        tx_ready = 1'b0;
        checks++;
        if (tx_q.size() != 0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL tx_ovf_drain: got %0d left tx_valid=%b want 0 0", tx_q.size(), tx_valid);
        end
        bus_write(2'd3, 32'h4);
        bus_read(28'd2, ST_IDLE);
        settle();
    endtask

    task automatic test_rx_underflow();
        stream_rx(16, 32'hA0);
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL rx_full_ready: got %b want 0", rx_ready);
        end
        bus_read(28'd2, 32'h00061000);
        for (int i = 0; i < 17; i++) begin
            bus_read(28'd1, (i < 16) ? 32'hA0 + 32'(i) : 32'h0);
            if (i == 0) begin
                checks++;
                if (rx_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL rx_ready_rise: got %b want 1", rx_ready);
                end
            end
        end
        bus_read(28'd2, 32'h002A0000);
        bus_write(2'd3, 32'h4);
        bus_read(28'd2, ST_IDLE);
        settle();
    endtask

    task automatic test_decode();
        bus_read(28'd4, 32'h0);
        bus_read(28'd5, 32'h0);
        bus_read(28'd2, ST_IDLE);
        bus_write(2'd1, 32'hBAD0);
        bus_read(28'd0, 32'h0);
        bus_read(28'd3, 32'h0);
        bus_read(28'd2, ST_IDLE);
        settle();
    endtask

    task automatic test_flush_collision();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) tx_write(32'h200 + 32'(i), 1'b1);
        stream_rx(3, 32'h300);
        // Flush both FIFOs while the TX stream pops and the RX stream pushes.
        bus.addr  = BASE + 28'd3;
        bus.wdata = 32'h3;
        bus.wr    = 1'b1;
        tx_ready  = 1'b1;
        rx_valid  = 1'b1;
        rx_data   = 32'hDEAD;
        step();
        bus.wr   = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        tx_q.delete();
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_tx_valid: got %b want 0", tx_valid);
        end
        bus_read(28'd2, ST_IDLE);
        settle();
    endtask

    task automatic test_reset_midop();
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) tx_write(32'h400 + 32'(i), 1'b1);
        stream_rx(8, 32'h500);
        bus.addr      = BASE + 28'd2;
        bus.rd        = 1'b1;
        drv_rd_mapped = 1'b1;
        rst           = 1'b1;
        step();
        bus.rd        = 1'b0;
        drv_rd_mapped = 1'b0;
        rst           = 1'b0;
        tx_q.delete();
        step();
        checks++;
        if (tx_valid !== 1'b0 || bus.rvalid !== 1'b0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_midop: got tx_valid=%b rvalid=%b rx_ready=%b want 0 0 1",
                     tx_valid, bus.rvalid, rx_ready);
        end
        bus_read(28'd2, ST_IDLE);
        settle();
    endtask

    task automatic test_back_to_back();
        stream_rx(3, 32'h600);
        for (int i = 0; i < 3; i++) bus_read(28'd1, 32'h600 + 32'(i));
        bus_read(28'd2, ST_IDLE);
        bus_read(28'd2, ST_IDLE);
        settle();
    endtask

    initial begin
        rst = 1'b1;
        bus.addr = '0;
        bus.wdata = '0;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data = '0;
        test_reset();
        test_tx_basic();
        test_tx_overflow();
        test_rx_underflow();
        test_decode();
        test_flush_collision();
        test_reset_midop();
        test_back_to_back();
        checks++;
        if (rd_q.size() != 0 || tx_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got rd=%0d tx=%0d pending want 0 0", rd_q.size(), tx_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
